// File: rtl/tile_reset_sequencer.sv
// Staggered per-tile reset sequencer: wake interval, in-order domain release, masked soft reset.
// Outputs lag rel_q by SYNC_STAGES edges; no backpressure, requests outside an idle RUN are dropped.
module tile_reset_sequencer #(
   parameter int NUM_DOMAINS    = 4,
   parameter int WAKE_CNT_WIDTH = 16,
   parameter int STAGGER_CYCLES = 8,
   parameter int HOLD_CYCLES    = 16,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                   clk_i,
   input  logic                   reset_l,
   input  logic                   soft_rst_req_i,
   input  logic [NUM_DOMAINS-1:0] soft_rst_mask_i,
   output logic [NUM_DOMAINS-1:0] domain_rst_no,
   output logic                   all_released_o,
   output logic                   busy_o
);

   localparam int CNT_MAX = (STAGGER_CYCLES > HOLD_CYCLES) ? STAGGER_CYCLES : HOLD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [1:0] ST_WAKE    = 2'd0;
   localparam logic [1:0] ST_RELEASE = 2'd1;
   localparam logic [1:0] ST_RUN     = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;

   localparam logic [WAKE_CNT_WIDTH-1:0] WAKE_LAST  = {1'b0, {(WAKE_CNT_WIDTH-1){1'b1}}};
   localparam logic [CNT_W-1:0]          STAGGER_LD = CNT_W'(STAGGER_CYCLES);
   localparam logic [CNT_W-1:0]          HOLD_LD    = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0]          CNT_ONE    = CNT_W'(1);

   logic [1:0]                state_q, state_d;
   logic [WAKE_CNT_WIDTH-1:0] wake_cnt_q, wake_cnt_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [NUM_DOMAINS-1:0]    rel_q, rel_d;
   logic [NUM_DOMAINS-1:0]    tgt_q, tgt_d;
   logic                      soft_pend_q, soft_pend_d;
   logic                      busy_q;

   logic [NUM_DOMAINS-1:0]    pending;
   logic [NUM_DOMAINS-1:0]    low_bit;
   logic                      last_bit;

   logic [NUM_DOMAINS-1:0]    sync_q [SYNC_STAGES];

   // Target bits not yet released; isolating the lowest one skips non-targets at no cost.
   always_comb begin
      pending  = tgt_q & ~rel_q;
      low_bit  = pending & (~pending + NUM_DOMAINS'(1));
      last_bit = ((pending & ~low_bit) == '0);
   end

   always_comb begin
      state_d     = state_q;
      wake_cnt_d  = wake_cnt_q;
      cnt_d       = cnt_q;
      rel_d       = rel_q;
      tgt_d       = tgt_q;
      soft_pend_d = soft_pend_q;

      if (!wake_cnt_q[WAKE_CNT_WIDTH-1]) begin
         wake_cnt_d = wake_cnt_q + WAKE_CNT_WIDTH'(1);
      end

      case (state_q)
         ST_WAKE: begin
            if (wake_cnt_q == WAKE_LAST) begin
               tgt_d    = '1;
               rel_d[0] = 1'b1;
               cnt_d    = STAGGER_LD;
               state_d  = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
            end
         end
         ST_RELEASE, ST_HOLD: begin
            if (cnt_q == CNT_ONE) begin
               rel_d   = rel_q | low_bit;
               cnt_d   = STAGGER_LD;
               state_d = last_bit ? ST_RUN : ST_RELEASE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            // The request is only latched here; the clear happens one edge later.
            if (soft_pend_q) begin
               rel_d       = rel_q & ~tgt_q;
               cnt_d       = HOLD_LD;
               soft_pend_d = 1'b0;
               state_d     = ST_HOLD;
            end else if (soft_rst_req_i && (soft_rst_mask_i != '0)) begin
               tgt_d       = soft_rst_mask_i;
               soft_pend_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         state_q     <= ST_WAKE;
         wake_cnt_q  <= '0;
         cnt_q       <= '0;
         rel_q       <= '0;
         tgt_q       <= '0;
         soft_pend_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         wake_cnt_q  <= wake_cnt_d;
         cnt_q       <= cnt_d;
         rel_q       <= rel_d;
         tgt_q       <= tgt_d;
         soft_pend_q <= soft_pend_d;
         busy_q      <= (state_d != ST_RUN);
      end
   end

   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= rel_q;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign domain_rst_no  = sync_q[SYNC_STAGES-1];
   assign all_released_o = &domain_rst_no;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_tile_reset_sequencer.sv
// Directed bench for tile_reset_sequencer: 4-domain test configuration plus a 1-domain boundary instance.
module tb_tile_reset_sequencer;

   logic       clk_i;
   logic       reset_l;
   logic       soft_rst_req_i;
   logic [3:0] soft_rst_mask_i;
   logic [3:0] domain_rst_no;
   logic       all_released_o;
   logic       busy_o;

   logic       req1;
   logic [0:0] mask1;
   logic [0:0] dom1;
   logic       all1;
   logic       busy1;

   int unsigned checks;
   int unsigned failures;

   tile_reset_sequencer #(
      .NUM_DOMAINS(4), .WAKE_CNT_WIDTH(4), .STAGGER_CYCLES(3), .HOLD_CYCLES(5), .SYNC_STAGES(2)
   ) dut (
      .clk_i(clk_i), .reset_l(reset_l),
      .soft_rst_req_i(soft_rst_req_i), .soft_rst_mask_i(soft_rst_mask_i),
      .domain_rst_no(domain_rst_no), .all_released_o(all_released_o), .busy_o(busy_o)
   );

   tile_reset_sequencer #(
      .NUM_DOMAINS(1), .WAKE_CNT_WIDTH(4), .STAGGER_CYCLES(1), .HOLD_CYCLES(5), .SYNC_STAGES(2)
   ) dut_b (
      .clk_i(clk_i), .reset_l(reset_l),
      .soft_rst_req_i(req1), .soft_rst_mask_i(mask1),
      .domain_rst_no(dom1), .all_released_o(all1), .busy_o(busy1)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Edges 1..n after reset release; optionally pulses requests at edges 5 (WAKE) and 12 (RELEASE).
   task automatic power_on(input bit inject, input int n);
      logic [3:0] exp_dom;
      for (int t = 1; t <= n; t++) begin
         if (inject && (t == 5 || t == 12)) begin
            soft_rst_req_i  = 1'b1;
            soft_rst_mask_i = 4'hF;
         end
         tick();
         soft_rst_req_i  = 1'b0;
         soft_rst_mask_i = 4'h0;
         exp_dom = {t >= 19, t >= 16, t >= 13, t >= 10};
         chk($sformatf("po_dom_e%0d", t), 32'(domain_rst_no), 32'(exp_dom));
         chk($sformatf("po_busy_e%0d", t), 32'(busy_o), 32'(t < 17));
         chk($sformatf("po_all_e%0d", t), 32'(all_released_o), 32'(t >= 19));
         chk($sformatf("b_dom_e%0d", t), 32'(dom1), 32'(t >= 10));
         chk($sformatf("b_all_e%0d", t), 32'(all1), 32'(t >= 10));
         chk($sformatf("b_busy_e%0d", t), 32'(busy1), 32'(t < 8));
      end
   endtask

   initial begin
      logic [3:0] exp_dom;
      checks          = 0;
      failures        = 0;
      reset_l         = 1'b0;
      soft_rst_req_i  = 1'b0;
      soft_rst_mask_i = 4'h0;
      req1            = 1'b0;
      mask1           = 1'b0;

      // Reset values
      tick();
      tick();
      chk("rst_dom", 32'(domain_rst_no), 32'h0);
      chk("rst_all", 32'(all_released_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h1);
      chk("rst_b_dom", 32'(dom1), 32'h0);
      reset_l = 1'b1;

      // Power-on release
      power_on(1'b0, 22);

      // Zero mask in RUN is ignored
      soft_rst_req_i  = 1'b1;
      soft_rst_mask_i = 4'h0;
      tick();
      soft_rst_req_i  = 1'b0;
      for (int r = 1; r <= 5; r++) begin
         tick();
         chk($sformatf("zmask_dom_r%0d", r), 32'(domain_rst_no), 32'hF);
         chk($sformatf("zmask_busy_r%0d", r), 32'(busy_o), 32'h0);
      end

      // Soft reset mask 0101, with an ignored request (mask 1010) during HOLD
      soft_rst_req_i  = 1'b1;
      soft_rst_mask_i = 4'b0101;
      tick();
      soft_rst_req_i  = 1'b0;
      soft_rst_mask_i = 4'h0;
      chk("sr5_dom_r0", 32'(domain_rst_no), 32'hF);
      chk("sr5_busy_r0", 32'(busy_o), 32'h0);
      for (int r = 1; r <= 13; r++) begin
         if (r == 3) begin
            soft_rst_req_i  = 1'b1;
            soft_rst_mask_i = 4'b1010;
         end
         tick();
         soft_rst_req_i  = 1'b0;
         soft_rst_mask_i = 4'h0;
         exp_dom = {1'b1, !(r >= 3 && r < 11), 1'b1, !(r >= 3 && r < 8)};
         chk($sformatf("sr5_dom_r%0d", r), 32'(domain_rst_no), 32'(exp_dom));
         chk($sformatf("sr5_busy_r%0d", r), 32'(busy_o), 32'(r >= 1 && r < 9));
         chk($sformatf("sr5_all_r%0d", r), 32'(all_released_o), 32'(!(r >= 3 && r < 11)));
         chk($sformatf("sr5_b_dom_r%0d", r), 32'(dom1), 32'h1);
      end

      // Single-bit mask 1000: no stagger after HOLD
      soft_rst_req_i  = 1'b1;
      soft_rst_mask_i = 4'b1000;
      tick();
      soft_rst_req_i  = 1'b0;
      soft_rst_mask_i = 4'h0;
      for (int r = 1; r <= 9; r++) begin
         tick();
         exp_dom = {!(r >= 3 && r < 8), 3'b111};
         chk($sformatf("sr8_dom_r%0d", r), 32'(domain_rst_no), 32'(exp_dom));
         chk($sformatf("sr8_busy_r%0d", r), 32'(busy_o), 32'(r >= 1 && r < 6));
      end

      // Reset asserted between edges 14 and 15
      reset_l = 1'b0;
      tick();
      reset_l = 1'b1;
      power_on(1'b0, 14);
      #3;
      reset_l = 1'b0;
      #1;
      chk("mid_dom", 32'(domain_rst_no), 32'h0);
      chk("mid_busy", 32'(busy_o), 32'h1);
      chk("mid_all", 32'(all_released_o), 32'h0);
      chk("mid_b_dom", 32'(dom1), 32'h0);
      tick();
      reset_l = 1'b1;

      // Power-on repeats; requests in WAKE and RELEASE are ignored
      power_on(1'b1, 22);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
